// File: rtl/axi_stream_input_if.sv
// AXI4-Stream channel for int8 feature-map samples; tuser carries the channel count.
interface axi_stream_input_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 7
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axi_stream_input.sv
// AXI4-Stream ingress: accepts int8 samples into a 2-entry skid buffer and writes
// them to the input SRAM at consecutive (wrapping) addresses, reporting framing status.
module axi_stream_input #(
  parameter int ADDR_WIDTH         = 13,
  parameter int DATA_WIDTH         = 8,
  parameter int MAX_ADDR_WIDTH     = 14,
  parameter int NUM_CHANNELS_WIDTH = $clog2(64 + 1)
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  axi_stream_input_if.slave             s_axis,
  output logic                          sram_in_en,
  output logic [ADDR_WIDTH-1:0]         sram_in_addr,
  output logic [DATA_WIDTH-1:0]         sram_in_data,
  input  logic                          sram_in_ready,
  input  logic                          start_input,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [MAX_ADDR_WIDTH-1:0]     in_size,
  output logic                          input_done,
  output logic                          tlast_err,
  output logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
  output logic [MAX_ADDR_WIDTH-1:0]     words_written
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  localparam logic [MAX_ADDR_WIDTH-1:0] CNT_ONE  = MAX_ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = ADDR_WIDTH'(1);

  state_t                    state, state_next;
  logic [MAX_ADDR_WIDTH-1:0] size_latched;
  logic [MAX_ADDR_WIDTH-1:0] accept_cnt;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     fifo_mem [2];
  logic                      fifo_rd_ptr;
  logic                      fifo_wr_ptr;
  logic [1:0]                fifo_count;

  logic active;
  logic push;
  logic pop;
  logic last_beat;
  logic final_beat;
  logic abort;

  // tready depends only on registers so the upstream valid/ready loop stays open.
  assign s_axis.tready = (state == RECV) && (fifo_count < 2'd2) && (accept_cnt < size_latched);

  assign active       = (state == RECV) || (state == DRAIN);
  assign push         = s_axis.tvalid && s_axis.tready;
  assign sram_in_en   = active && (fifo_count != 2'd0);
  assign pop          = sram_in_en && sram_in_ready;
  assign last_beat    = (accept_cnt == size_latched - CNT_ONE);
  assign final_beat   = push && (last_beat || s_axis.tlast);
  assign abort        = active && !start_input;
  assign sram_in_addr = wr_addr;
  assign sram_in_data = fifo_mem[fifo_rd_ptr];
  assign input_done   = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) state <= IDLE;
    else                 state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_input) state_next = (in_size != '0) ? RECV : DONE;
      RECV:    if (!start_input)            state_next = IDLE;
               else if (final_beat)         state_next = DRAIN;
      DRAIN:   if (!start_input)            state_next = IDLE;
               else if (fifo_count == 2'd0) state_next = DONE;
      DONE:    if (!start_input)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      size_latched  <= '0;
      accept_cnt    <= '0;
      wr_addr       <= '0;
      words_written <= '0;
      tlast_err     <= 1'b0;
      num_channels  <= '0;
      fifo_rd_ptr   <= 1'b0;
      fifo_wr_ptr   <= 1'b0;
      fifo_count    <= 2'd0;
      // NOTE: the skid storage is only two words, so it is reset too; this keeps
      // sram_in_data at zero out of reset instead of exposing X.
      fifo_mem[0]   <= '0;
      fifo_mem[1]   <= '0;
    end else begin
      if (state == IDLE && start_input) begin
        size_latched  <= in_size;
        accept_cnt    <= '0;
        wr_addr       <= base_addr;
        words_written <= '0;
        tlast_err     <= 1'b0;
        num_channels  <= '0;
      end

      // A write presented with ready high completes even in the abort cycle.
      if (pop) begin
        wr_addr       <= wr_addr + ADDR_ONE;
        words_written <= words_written + CNT_ONE;
      end

      if (abort) begin
        fifo_rd_ptr <= 1'b0;
        fifo_wr_ptr <= 1'b0;
        fifo_count  <= 2'd0;
      end else begin
        if (push) begin
          fifo_mem[fifo_wr_ptr] <= s_axis.tdata;
          fifo_wr_ptr           <= ~fifo_wr_ptr;
          accept_cnt            <= accept_cnt + CNT_ONE;
          if (accept_cnt == '0)                 num_channels <= s_axis.tuser;
          if (s_axis.tlast != last_beat)        tlast_err    <= 1'b1;
        end
        if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
        unique case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 2'd1;
          2'b01:   fifo_count <= fifo_count - 2'd1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

endmodule
